// File: rtl/qdec_cabac_dec_arb.sv
// Purpose : arbitrates ownership of the shared CABAC decode engine among four
//           decoder sub-FSMs. It muxes the owner's engine controls onto the
//           engine and routes the decoded bins back to the owner.
// Latency : grant is issued 1 cycle after a request is seen in ARB_IDLE.
//           Owner controls reach the engine 1 cycle after they are driven.
//           A bin reaches the owner 1 cycle after ruiBin_vld.
// Backpressure: none toward the engine. dec_rdy is informational only, and the
//           owner sub-FSM paces its own dec_run. Ownership is held until
//           own_rel, then until every in-flight bin has returned.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   own_req[3:0], own_rel[3:0]  per-requester ownership request (level) / release (pulse)
//   req_ctx_addr[39:0]          four packed 10-bit context addresses, requester i at [10i+9:10i]
//   req_ctx_addr_vld, req_dec_run, req_ep_mode [3:0]   per-requester engine controls
//   gnt[3:0]                    one-hot owner, zero when unowned
//   ctx_addr, ctx_addr_vld, dec_run, EPMode            registered engine controls
//   dec_rdy, ruiBin, ruiBin_vld engine status and decoded bin
//   bin_out, bin_vld_out[3:0]   decoded bin routed to the owner
//   busy, err_flags[2:0]        not idle; sticky {bin_underflow, outstanding_overflow, illegal_drive}
//
// Build option: define QDEC_ARB_ROUND_ROBIN_EN to get round-robin winner selection.
// The default is fixed priority, where the lowest requesting index wins.

module qdec_cabac_dec_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  own_req,
   input  logic [3:0]  own_rel,
   input  logic [39:0] req_ctx_addr,
   input  logic [3:0]  req_ctx_addr_vld,
   input  logic [3:0]  req_dec_run,
   input  logic [3:0]  req_ep_mode,
   output logic [3:0]  gnt,
   output logic [9:0]  ctx_addr,
   output logic        ctx_addr_vld,
   output logic        dec_run,
   output logic        EPMode,
   input  logic        dec_rdy,
   input  logic        ruiBin,
   input  logic        ruiBin_vld,
   output logic        bin_out,
   output logic [3:0]  bin_vld_out,
   output logic        busy,
   output logic [2:0]  err_flags
);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_t;

   arb_state_t  state;
   logic [1:0]  owner;
   logic [3:0]  outstanding;
   logic [1:0]  win_idx;
   logic [9:0]  addr_arr [4];

   logic        underflow;
   logic        overflow;
   logic        illegal;
   logic        eff_dec;
   logic [3:0]  out_nxt;
   logic        unused_ok;

`ifdef QDEC_ARB_ROUND_ROBIN_EN
   logic [1:0]  rr_ptr;   // index of the most recent grantee
   logic [1:0]  cand;
`endif

   // dec_rdy carries no control meaning here. The owner watches it directly.
   assign unused_ok = &{1'b0, dec_rdy};

   assign busy = (state != ARB_IDLE);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         addr_arr[i] = req_ctx_addr[10*i +: 10];
      end
   end

   // Winner selection. The loop runs from lowest priority to highest, so the
   // last hit is the winner.
   always_comb begin
      win_idx = 2'd0;
`ifdef QDEC_ARB_ROUND_ROBIN_EN
      cand = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = rr_ptr + 2'(k);
         if (own_req[cand]) begin
            win_idx = cand;
         end
      end
`else
      for (int k = 3; k >= 0; k--) begin
         if (own_req[k]) begin
            win_idx = 2'(k);
         end
      end
`endif
   end

   // Outstanding-bin bookkeeping. A bin that arrives when nothing is
   // outstanding is dropped and does not count as a decrement.
   always_comb begin
      underflow = ruiBin_vld && (outstanding == 4'd0);
      eff_dec   = ruiBin_vld && !underflow;
      overflow  = dec_run && !eff_dec && (outstanding == 4'd15);
      out_nxt   = outstanding;
      if (dec_run && !eff_dec) begin
         out_nxt = (outstanding == 4'd15) ? 4'd15 : outstanding + 4'd1;
      end else if (!dec_run && eff_dec) begin
         out_nxt = outstanding - 4'd1;
      end
      // Any engine control from a non-owner while ownership is held is a protocol error.
      illegal = (state != ARB_IDLE) && (|(~gnt & (req_ctx_addr_vld | req_dec_run)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         owner        <= 2'd0;
         gnt          <= 4'd0;
         ctx_addr     <= 10'd0;
         ctx_addr_vld <= 1'b0;
         dec_run      <= 1'b0;
         EPMode       <= 1'b0;
         bin_out      <= 1'b0;
         bin_vld_out  <= 4'd0;
         outstanding  <= 4'd0;
         err_flags    <= 3'd0;
`ifdef QDEC_ARB_ROUND_ROBIN_EN
         rr_ptr       <= 2'd3;
`endif
      end else begin
         err_flags   <= err_flags | {underflow, overflow, illegal};
         outstanding <= out_nxt;

         // Bins go to the current owner. Outside ownership they are absorbed.
         bin_vld_out <= 4'd0;
         if (eff_dec && (state != ARB_IDLE)) begin
            bin_vld_out <= gnt;
            bin_out     <= ruiBin;
         end

         case (state)
            ARB_IDLE: begin
               ctx_addr_vld <= 1'b0;
               dec_run      <= 1'b0;
               if (|own_req) begin
                  state <= ARB_GRANT;
                  owner <= win_idx;
                  gnt   <= 4'b0001 << win_idx;
`ifdef QDEC_ARB_ROUND_ROBIN_EN
                  rr_ptr <= win_idx;
`endif
               end
            end

            ARB_GRANT: begin
               if (own_rel[owner]) begin
                  // Controls driven together with the release are discarded.
                  // As a result, no new work is issued once ownership ends.
                  ctx_addr_vld <= 1'b0;
                  dec_run      <= 1'b0;
                  if (out_nxt == 4'd0) begin
                     state <= ARB_IDLE;
                     gnt   <= 4'd0;
                  end else begin
                     state <= ARB_DRAIN;
                  end
               end else begin
                  ctx_addr     <= addr_arr[owner];
                  ctx_addr_vld <= req_ctx_addr_vld[owner];
                  dec_run      <= req_dec_run[owner];
                  EPMode       <= req_ep_mode[owner];
               end
            end

            ARB_DRAIN: begin
               ctx_addr_vld <= 1'b0;
               dec_run      <= 1'b0;
               if (out_nxt == 4'd0) begin
                  state <= ARB_IDLE;
                  gnt   <= 4'd0;
               end
            end

            default: begin
               state        <= ARB_IDLE;
               gnt          <= 4'd0;
               ctx_addr_vld <= 1'b0;
               dec_run      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qdec_cabac_dec_arb.sv
// Directed bench for qdec_cabac_dec_arb. It checks grant, control muxing,
// drain, bin routing, error flags and reset.
module tb_qdec_cabac_dec_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  own_req, own_rel;
   logic [39:0] req_ctx_addr;
   logic [3:0]  req_ctx_addr_vld, req_dec_run, req_ep_mode;
   logic [3:0]  gnt;
   logic [9:0]  ctx_addr;
   logic        ctx_addr_vld, dec_run, EPMode;
   logic        dec_rdy, ruiBin, ruiBin_vld;
   logic        bin_out;
   logic [3:0]  bin_vld_out;
   logic        busy;
   logic [2:0]  err_flags;

   int n_cmp = 0;
   int n_bad = 0;

   qdec_cabac_dec_arb dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .own_req          (own_req),
      .own_rel          (own_rel),
      .req_ctx_addr     (req_ctx_addr),
      .req_ctx_addr_vld (req_ctx_addr_vld),
      .req_dec_run      (req_dec_run),
      .req_ep_mode      (req_ep_mode),
      .gnt              (gnt),
      .ctx_addr         (ctx_addr),
      .ctx_addr_vld     (ctx_addr_vld),
      .dec_run          (dec_run),
      .EPMode           (EPMode),
      .dec_rdy          (dec_rdy),
      .ruiBin           (ruiBin),
      .ruiBin_vld       (ruiBin_vld),
      .bin_out          (bin_out),
      .bin_vld_out      (bin_vld_out),
      .busy             (busy),
      .err_flags        (err_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      own_req = 4'd0; own_rel = 4'd0; req_ctx_addr = 40'd0;
      req_ctx_addr_vld = 4'd0; req_dec_run = 4'd0; req_ep_mode = 4'd0;
      dec_rdy = 1'b1; ruiBin = 1'b0; ruiBin_vld = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [3:0] exp_g [3];

   initial begin
`ifdef QDEC_ARB_ROUND_ROBIN_EN
      exp_g = '{4'b0010, 4'b1000, 4'b0010};
`else
      exp_g = '{4'b0010, 4'b0010, 4'b0010};
`endif
      // Reset state
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ctx", 32'(ctx_addr), 32'h0);
      chk("rst_vld", 32'(ctx_addr_vld), 32'h0);
      chk("rst_run", 32'(dec_run), 32'h0);
      chk("rst_ep", 32'(EPMode), 32'h0);
      chk("rst_binv", 32'(bin_vld_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err_flags), 32'h0);

      // Single requester 2; control path; a non-owner address must not leak
      own_req = 4'b0100;
      step();
      chk("g2_gnt", 32'(gnt), 32'h4);
      chk("g2_busy", 32'(busy), 32'h1);
      req_ctx_addr[29:20] = 10'h05A;
      req_ctx_addr[9:0]   = 10'h3FF;
      req_ctx_addr_vld    = 4'b0100;
      req_ep_mode         = 4'b0100;
      step();
      chk("g2_ctx", 32'(ctx_addr), 32'h05A);
      chk("g2_vld", 32'(ctx_addr_vld), 32'h1);
      chk("g2_ep", 32'(EPMode), 32'h1);
      chk("g2_err", 32'(err_flags), 32'h0);
      req_ctx_addr_vld = 4'd0;
      own_rel = 4'b0100;
      own_req = 4'd0;
      step();
      own_rel = 4'd0;
      chk("g2_rel_gnt", 32'(gnt), 32'h0);
      chk("g2_rel_busy", 32'(busy), 32'h0);
      chk("g2_rel_vld", 32'(ctx_addr_vld), 32'h0);

      // Bin arriving while idle with nothing outstanding
      ruiBin = 1'b1; ruiBin_vld = 1'b1;
      step();
      ruiBin_vld = 1'b0;
      chk("unf_binv", 32'(bin_vld_out), 32'h0);
      chk("unf_err", 32'(err_flags), 32'h4);
      step();
      chk("unf_sticky", 32'(err_flags), 32'h4);
      do_reset();

      // Non-owner drives dec_run while requester 0 owns the engine
      own_req = 4'b0001;
      step();
      chk("ill_gnt", 32'(gnt), 32'h1);
      req_dec_run = 4'b0100;
      step();
      chk("ill_run", 32'(dec_run), 32'h0);
      chk("ill_err", 32'(err_flags), 32'h1);
      req_dec_run = 4'b0001;
      step();
      chk("own_run", 32'(dec_run), 32'h1);
      req_dec_run = 4'b0000;
      step();
      ruiBin = 1'b1; ruiBin_vld = 1'b1;
      step();
      ruiBin_vld = 1'b0;
      chk("own_binv", 32'(bin_vld_out), 32'h1);
      chk("own_bin", 32'(bin_out), 32'h1);
      chk("own_err", 32'(err_flags), 32'h1);
      own_rel = 4'b0001; own_req = 4'd0;
      step();
      own_rel = 4'd0;
      chk("own_rel_gnt", 32'(gnt), 32'h0);
      do_reset();

      // Release with two bins in flight causes a drain
      own_req = 4'b0010;
      step();
      req_dec_run = 4'b0010;
      step();
      step();
      chk("dr_run2", 32'(dec_run), 32'h1);
      req_dec_run = 4'd0; own_rel = 4'b0010; own_req = 4'd0;
      step();
      own_rel = 4'd0;
      chk("dr_busy", 32'(busy), 32'h1);
      chk("dr_gnt", 32'(gnt), 32'h2);
      chk("dr_run", 32'(dec_run), 32'h0);
      chk("dr_vld", 32'(ctx_addr_vld), 32'h0);
      ruiBin = 1'b1; ruiBin_vld = 1'b1;
      step();
      chk("dr_b1v", 32'(bin_vld_out), 32'h2);
      chk("dr_b1", 32'(bin_out), 32'h1);
      chk("dr_b1_gnt", 32'(gnt), 32'h2);
      ruiBin = 1'b0;
      step();
      ruiBin_vld = 1'b0;
      chk("dr_b2v", 32'(bin_vld_out), 32'h2);
      chk("dr_b2", 32'(bin_out), 32'h0);
      chk("dr_end_gnt", 32'(gnt), 32'h0);
      chk("dr_end_busy", 32'(busy), 32'h0);
      step();
      chk("dr_binv0", 32'(bin_vld_out), 32'h0);
      chk("dr_err", 32'(err_flags), 32'h0);

      // Reset in the middle of a drain with three bins outstanding
      own_req = 4'b1000;
      step();
      chk("rd_gnt", 32'(gnt), 32'h8);
      req_dec_run = 4'b1000;
      step(); step(); step();
      req_dec_run = 4'd0; own_rel = 4'b1000; own_req = 4'd0;
      step();
      own_rel = 4'd0;
      chk("rd_busy", 32'(busy), 32'h1);
      chk("rd_outst", 32'(dut.outstanding), 32'h3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rd_gnt0", 32'(gnt), 32'h0);
      chk("rd_busy0", 32'(busy), 32'h0);
      chk("rd_run0", 32'(dec_run), 32'h0);
      chk("rd_ctx0", 32'(ctx_addr), 32'h0);
      chk("rd_outst0", 32'(dut.outstanding), 32'h0);
      ruiBin_vld = 1'b1;
      step();
      ruiBin_vld = 1'b0;
      chk("rd_late_binv", 32'(bin_vld_out), 32'h0);
      chk("rd_late_err", 32'(err_flags), 32'h4);
      do_reset();

      // Two requesters held; each owner takes one bin and then releases
      own_req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_g[i]));
         req_dec_run = exp_g[i];
         step();
         req_dec_run = 4'd0;
         step();
         ruiBin = 1'b1; ruiBin_vld = 1'b1;
         step();
         ruiBin_vld = 1'b0;
         chk($sformatf("rr_binv%0d", i), 32'(bin_vld_out), 32'(exp_g[i]));
         own_rel = exp_g[i];
         step();
         own_rel = 4'd0;
         chk($sformatf("rr_idle%0d", i), 32'(gnt), 32'h0);
      end
      own_req = 4'd0;
      step();
      chk("rr_done_gnt", 32'(gnt), 32'h0);
      chk("rr_err", 32'(err_flags), 32'h0);

      // Outstanding counter saturates at 15
      own_req = 4'b0001;
      step();
      req_dec_run = 4'b0001;
      for (int i = 0; i < 16; i++) step();
      chk("ovf_pre_cnt", 32'(dut.outstanding), 32'hF);
      chk("ovf_pre_err", 32'(err_flags), 32'h0);
      step();
      chk("ovf_cnt", 32'(dut.outstanding), 32'hF);
      chk("ovf_err", 32'(err_flags), 32'h2);
      do_reset();
      chk("end_err", 32'(err_flags), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
